// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state codes,
// preamble pattern and the frame-length clamp helper.
package serial_tx_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_GAP   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // Preamble bits are sent from the MSB down: 1 then 0.
   localparam logic [1:0]  PREAMBLE     = 2'b10;
   localparam int unsigned PREAMBLE_LEN = 2;

   // A length of 0 or one larger than the word means "the whole word".
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
      return ((len == 0) || (len > width)) ? width : len;
   endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// Loadable MSB-first shift register with a bits-remaining counter.
// Load emits the first bit combinationally (first_o) and stores the rest,
// so the top can register that bit on the same edge it accepts the frame.
module serial_tx_shifter
   import serial_tx_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] word_i,
   input  logic [LW-1:0]    len_i,
   output logic             first_o,
   output logic             bit_o,
   output logic             last_o
);

   logic [WIDTH-1:0] aligned;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [LW-1:0]    cnt_q, cnt_d;

   // Left-align the frame so bit len-1 sits at the register MSB.
   always_comb begin
      aligned = word_i << (LW'(WIDTH) - len_i);
   end

   // Load drops the bit already emitted; shifting stops once nothing remains.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = {aligned[WIDTH-2:0], 1'b0};
         cnt_d = len_i - LW'(1);
      end else if (shift_i && (cnt_q != '0)) begin
         sr_d  = {sr_q[WIDTH-2:0], 1'b0};
         cnt_d = cnt_q - LW'(1);
      end
   end

   // Shift register and counter state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign first_o = aligned[WIDTH-1];
   assign bit_o   = sr_q[WIDTH-1];
   assign last_o  = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a captured word MSB-first on O, followed
// by a zero gap, optionally repeated, with busy/done status.
// Optional feature macro: SERIAL_TX_PREAMBLE_EN (1,0 preamble before each frame).
module serial_pattern_tx
   import serial_tx_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned REP_W      = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WIDTH-1:0]           data,
   input  logic [$clog2(WIDTH+1)-1:0] len,
   input  logic [REP_W-1:0]           rep,
   output logic                       O,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned LW = $clog2(WIDTH + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [LW-1:0]    len_q, len_d, len_c;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             o_q, o_d, busy_q, busy_d, done_q, done_d;
   logic             accept, begin_frame, load, shift;
   logic             sh_first, sh_bit, sh_last;
`ifdef SERIAL_TX_PREAMBLE_EN
   localparam int unsigned PW = $clog2(PREAMBLE_LEN);
   logic [PW-1:0]    pre_q, pre_d;
`endif

   // Capture word/length on accept; the shifter loads from the _d values so
   // the first bit is available on the accepting edge itself.
   always_comb begin
      accept = (state_q == ST_IDLE) && start;
      len_c  = LW'(clamp_len(32'(len), WIDTH));
      word_d = accept ? data  : word_q;
      len_d  = accept ? len_c : len_q;
   end

   serial_tx_shifter #(
      .WIDTH (WIDTH),
      .LW    (LW)
   ) u_shifter (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .shift_i (shift),
      .word_i  (word_d),
      .len_i   (len_d),
      .first_o (sh_first),
      .bit_o   (sh_bit),
      .last_o  (sh_last)
   );

   // Frame sequencing; o_d is the value O will hold in the next cycle.
   always_comb begin
      state_d     = state_q;
      rep_d       = rep_q;
      gap_d       = gap_q;
      o_d         = 1'b0;
      load        = 1'b0;
      shift       = 1'b0;
      begin_frame = 1'b0;
`ifdef SERIAL_TX_PREAMBLE_EN
      pre_d       = pre_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rep_d       = rep;
               begin_frame = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (sh_last) begin
               state_d = ST_GAP;
               gap_d   = GW'(GAP_CYCLES - 1);
            end else begin
               shift = 1'b1;
               o_d   = sh_bit;
            end
         end
         ST_GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GW'(1);
            end else if (rep_q != '0) begin
               rep_d       = rep_q - REP_W'(1);
               begin_frame = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
`ifdef SERIAL_TX_PREAMBLE_EN
         ST_PRE: begin
            if (pre_q != '0) begin
               o_d   = PREAMBLE[pre_q - PW'(1)];
               pre_d = pre_q - PW'(1);
            end else begin
               state_d = ST_SHIFT;
               load    = 1'b1;
               o_d     = sh_first;
            end
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (begin_frame) begin
`ifdef SERIAL_TX_PREAMBLE_EN
         state_d = ST_PRE;
         pre_d   = PW'(PREAMBLE_LEN - 1);
         o_d     = PREAMBLE[PREAMBLE_LEN-1];
`else
         state_d = ST_SHIFT;
         load    = 1'b1;
         o_d     = sh_first;
`endif
      end
      busy_d = (state_d == ST_SHIFT) || (state_d == ST_GAP) || (state_d == ST_PRE);
      done_d = (state_d == ST_DONE);
   end

   // State, captured frame and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         len_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         o_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         len_q   <= len_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         o_q     <= o_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef SERIAL_TX_PREAMBLE_EN
   // Preamble position counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pre_q <= '0;
      else        pre_q <= pre_d;
   end
`endif

   assign O    = o_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx (WIDTH=8, GAP_CYCLES=1, REP_W=4).
// Expected waveforms come from a frame-level model: per frame, optional
// preamble, then bits len-1..0, then gap zeros; then one done cycle, then idle.
module tb_serial_pattern_tx;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned GAP   = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] data;
   logic [3:0] len;
   logic [3:0] rep;
   logic       O, busy, done;

   int tests = 0;
   int fails = 0;

   logic [2:0] exp_q[$];   // {O, busy, done} per cycle after the accepting edge
   logic [2:0] obs_q[$];

   serial_pattern_tx #(
      .WIDTH      (8),
      .GAP_CYCLES (1),
      .REP_W      (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .data  (data),
      .len   (len),
      .rep   (rep),
      .O     (O),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void build(input logic [7:0] d, input int unsigned l, input int unsigned r);
      int unsigned nbits;
      nbits = ((l == 0) || (l > WIDTH)) ? WIDTH : l;
      exp_q.delete();
      for (int unsigned f = 0; f <= r; f++) begin
`ifdef SERIAL_TX_PREAMBLE_EN
         exp_q.push_back(3'b110);
         exp_q.push_back(3'b010);
`endif
         for (int k = int'(nbits) - 1; k >= 0; k--) exp_q.push_back({d[k], 2'b10});
         for (int unsigned g = 0; g < GAP; g++) exp_q.push_back(3'b010);
      end
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b000);
   endfunction

   task automatic kick(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
      @(negedge clk);
      data  = d;
      len   = l;
      rep   = r;
      start = 1'b1;
      @(posedge clk);
   endtask

   // mode 0: drop start; 1: random input churn while busy; 2: hold start; 3: overwrite data/len mid-frame
   task automatic capture(input int n, input int mode);
      obs_q.delete();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs_q.push_back({O, busy, done});
         case (mode)
            0: start = 1'b0;
            1: begin
               if (i < n - 2) begin
                  start = 1'($urandom_range(0, 1));
                  data  = 8'($urandom);
                  len   = 4'($urandom_range(0, 15));
                  rep   = 4'($urandom_range(0, 15));
               end else begin
                  start = 1'b0;
               end
            end
            2: ;
            default: begin
               start = 1'b0;
               if (i == 2) begin
                  data = 8'h00;
                  len  = 4'd1;
                  rep  = 4'd0;
               end
            end
         endcase
      end
   endtask

   task automatic drain();
      int k = 0;
      while (((busy !== 1'b0) || (done !== 1'b0)) && (k < 200)) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      data  = '0;
      len   = '0;
      rep   = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if ({O, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_hold[%0d]: O/busy/done=%b, expected 000", i, {O, busy, done});
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({O, busy, done} !== 3'b000) begin
         fails++;
         $display("FAIL reset_release_idle: O/busy/done=%b, expected 000", {O, busy, done});
      end
   endtask

   task automatic test_directed(input string name, input logic [7:0] d, input logic [3:0] l,
                                input logic [3:0] r);
      build(d, l, r);
      kick(d, l, r);
      capture(exp_q.size(), 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL %s cycle %0d: O/busy/done=%b, expected %b", name, i + 1, obs_q[i], exp_q[i]);
         end
      end
      drain();
   endtask

   task automatic test_start_held();
      int unsigned period;
      build(8'hFF, 2, 0);
      period = exp_q.size();
      kick(8'hFF, 4'd2, 4'd0);
      capture(20, 2);
      for (int i = 0; i < 20; i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i % period]) begin
            fails++;
            $display("FAIL start_held cycle %0d: O/busy/done=%b, expected %b",
                     i + 1, obs_q[i], exp_q[i % period]);
         end
      end
      start = 1'b0;
      @(negedge clk);
      drain();
   endtask

   task automatic test_mid_change();
      build(8'hA5, 0, 0);
      kick(8'hA5, 4'd0, 4'd0);
      capture(exp_q.size(), 3);
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++;
         if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL mid_change cycle %0d: O/busy/done=%b, expected %b", i + 1, obs_q[i], exp_q[i]);
         end
      end
      drain();
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [3:0] l, r;
      for (int t = 0; t < 25; t++) begin
         d = 8'($urandom);
         l = 4'($urandom_range(0, 15));
         r = 4'($urandom_range(0, 3));
         build(d, l, r);
         kick(d, l, r);
         capture(exp_q.size(), 1);
         for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
               fails++;
               $display("FAIL random[%0d] d=%h len=%0d rep=%0d cycle %0d: O/busy/done=%b, expected %b",
                        t, d, l, r, i + 1, obs_q[i], exp_q[i]);
            end
         end
         drain();
      end
   endtask

   task automatic test_async_reset();
      kick(8'hA5, 4'd0, 4'd0);
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({O, busy, done} !== 3'b110) begin
         fails++;
         $display("FAIL pre_reset_frame: O/busy/done=%b, expected 110", {O, busy, done});
      end
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({O, busy, done} !== 3'b000) begin
         fails++;
         $display("FAIL async_reset_immediate: O/busy/done=%b, expected 000", {O, busy, done});
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if ({O, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset_hold[%0d]: O/busy/done=%b, expected 000", i, {O, busy, done});
         end
      end
      reset = 1'b1;
      test_directed("after_reset", 8'h3C, 4'd6, 4'd1);
   endtask

   initial begin
      test_reset();
      test_directed("a5_full", 8'hA5, 4'd0, 4'd0);
      test_directed("rep1_len3", 8'h06, 4'd3, 4'd1);
      test_directed("len1", 8'h01, 4'd1, 4'd2);
      test_directed("len_over", 8'hC3, 4'd15, 4'd0);
      test_directed("len_max", 8'h81, 4'd8, 4'd0);
      test_start_held();
      test_mid_change();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
